// File: rtl/arp_tx_framer.sv
// arp_tx_framer: frames an upstream body into a GMII byte stream with
// preamble, SFD, zero padding, CRC-32 FCS and inter-frame gap.
module arp_tx_framer #(
  parameter int MIN_LEN   = 60,
  parameter int MAX_LEN   = 1514,
  parameter int IFG_BYTES = 12
) (
  input  logic        CLK,
  input  logic        ARESET,
  input  logic        S_VALID,
  input  logic [7:0]  S_DATA,
  output logic        S_ACK,
  output logic [7:0]  GMII_TXD,
  output logic        GMII_TX_EN,
  output logic        ERR_OVERSIZE,
  output logic [15:0] FRAME_CNT
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, PAYLOAD, PAD, FCS, IFG
  } state_t;

  localparam logic [10:0] MIN_C    = 11'(MIN_LEN);
  localparam logic [10:0] MAX_C    = 11'(MAX_LEN);
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  state_t      state, state_n;
  logic [10:0] cnt, cnt_n;
  logic [31:0] crc, crc_n;
  logic [2:0]  sub, sub_n;
  logic [15:0] icnt, icnt_n;
  logic        ovs, ovs_n;
  logic        drain_ok, drain_n;
  logic [7:0]  txd_n;
  logic        txen_n, ack_n, err_n;
  logic [15:0] fcnt_n;
  logic [31:0] fcs_w;

  // a truncated frame goes out with the raw register so receivers drop it
  assign fcs_w = ovs ? crc : ~crc;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    crc_n   = crc;
    sub_n   = sub;
    icnt_n  = icnt;
    ovs_n   = ovs;
    drain_n = drain_ok | ~S_VALID;
    txd_n   = 8'h00;
    txen_n  = 1'b0;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    fcnt_n  = FRAME_CNT;
    unique case (state)
      IDLE: begin
        cnt_n  = '0;
        crc_n  = '1;
        sub_n  = '0;
        icnt_n = '0;
        ovs_n  = 1'b0;
        if (S_VALID && drain_ok) begin
          txd_n   = 8'h55;
          txen_n  = 1'b1;
          sub_n   = 3'd1;
          state_n = PREAMBLE;
        end
      end
      PREAMBLE: begin
        txen_n = 1'b1;
        if (sub == 3'd7) begin
          txd_n   = 8'hD5;
          ack_n   = 1'b1;
          state_n = PAYLOAD;
        end else begin
          txd_n = 8'h55;
          sub_n = sub + 3'd1;
        end
      end
      PAYLOAD: begin
        txen_n = 1'b1;
        if (S_VALID && cnt < MAX_C) begin
          txd_n = S_DATA;
          crc_n = crc_byte(crc, S_DATA);
          cnt_n = cnt + 11'd1;
          if (cnt + 11'd1 == MAX_C) begin
            ovs_n   = 1'b1;
            err_n   = 1'b1;
            drain_n = 1'b0;
            sub_n   = 3'd0;
            state_n = FCS;
          end
        end else if (cnt < MIN_C) begin
          crc_n   = crc_byte(crc, 8'h00);
          cnt_n   = cnt + 11'd1;
          state_n = PAD;
        end else begin
          txd_n   = fcs_w[7:0];
          sub_n   = 3'd1;
          state_n = FCS;
        end
      end
      PAD: begin
        txen_n = 1'b1;
        if (cnt < MIN_C) begin
          crc_n = crc_byte(crc, 8'h00);
          cnt_n = cnt + 11'd1;
        end else begin
          txd_n   = fcs_w[7:0];
          sub_n   = 3'd1;
          state_n = FCS;
        end
      end
      FCS: begin
        txen_n = 1'b1;
        txd_n  = fcs_w[{sub[1:0], 3'b000} +: 8];
        if (sub[1:0] == 2'd3) begin
          fcnt_n  = FRAME_CNT + 16'd1;
          icnt_n  = '0;
          state_n = IFG;
        end else begin
          sub_n = sub + 3'd1;
        end
      end
      IFG: begin
        if (icnt == IFG_LAST) state_n = IDLE;
        else icnt_n = icnt + 16'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge ARESET) begin
    if (ARESET) begin
      state        <= IDLE;
      cnt          <= '0;
      crc          <= '1;
      sub          <= '0;
      icnt         <= '0;
      ovs          <= 1'b0;
      drain_ok     <= 1'b1;
      GMII_TXD     <= 8'h00;
      GMII_TX_EN   <= 1'b0;
      S_ACK        <= 1'b0;
      ERR_OVERSIZE <= 1'b0;
      FRAME_CNT    <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      crc          <= crc_n;
      sub          <= sub_n;
      icnt         <= icnt_n;
      ovs          <= ovs_n;
      drain_ok     <= drain_n;
      GMII_TXD     <= txd_n;
      GMII_TX_EN   <= txen_n;
      S_ACK        <= ack_n;
      ERR_OVERSIZE <= err_n;
      FRAME_CNT    <= fcnt_n;
    end
  end

endmodule

// File: tb/tb_arp_tx_framer.sv
// tb_arp_tx_framer: scoreboard bench, two framer configurations
// (defaults, and MIN_LEN=1/MAX_LEN=64).
module tb_arp_tx_framer;

  logic       clk;
  logic       areset;
  logic       sv   [2];
  logic [7:0] sd   [2];
  logic       ack  [2];
  logic [7:0] txd  [2];
  logic       txen [2];
  logic       ovs  [2];
  logic [15:0] fcnt [2];

  int checks = 0;
  int failures = 0;

  logic [7:0] expq [2][$];
  int         lenq [2][$];
  logic [7:0] body [$];
  int fexp [2];
  int run [2], gap [2], last_gap [2];
  int ack_n [2], ovs_n [2], hi_n [2];
  logic prev [2];

  arp_tx_framer #(.MIN_LEN(60), .MAX_LEN(1514), .IFG_BYTES(12)) u_a (
    .CLK(clk), .ARESET(areset),
    .S_VALID(sv[0]), .S_DATA(sd[0]), .S_ACK(ack[0]),
    .GMII_TXD(txd[0]), .GMII_TX_EN(txen[0]),
    .ERR_OVERSIZE(ovs[0]), .FRAME_CNT(fcnt[0])
  );

  arp_tx_framer #(.MIN_LEN(1), .MAX_LEN(64), .IFG_BYTES(12)) u_b (
    .CLK(clk), .ARESET(areset),
    .S_VALID(sv[1]), .S_DATA(sd[1]), .S_ACK(ack[1]),
    .GMII_TXD(txd[1]), .GMII_TX_EN(txen[1]),
    .ERR_OVERSIZE(ovs[1]), .FRAME_CNT(fcnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] crc_upd(
    input logic [31:0] c,
    input logic [7:0] d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else r = r >> 1;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic mon(input int g);
    logic [7:0] e;
    int l;
    if (areset) begin
      prev[g] = 1'b0;
      run[g] = 0;
      gap[g] = 0;
      return;
    end
    if (ack[g]) ack_n[g]++;
    if (ovs[g]) ovs_n[g]++;
    if (txen[g]) begin
      hi_n[g]++;
      if (!prev[g]) begin
        last_gap[g] = gap[g];
        run[g] = 0;
      end
      run[g]++;
      checks++;
      if (expq[g].size() == 0) begin
        failures++;
        $display("FAIL txd dut%0d unexpected byte got=%02h required=none",
                 g, txd[g]);
      end else begin
        e = expq[g].pop_front();
        if (txd[g] !== e) begin
          failures++;
          $display("FAIL txd dut%0d got=%02h required=%02h", g, txd[g], e);
        end
      end
    end else begin
      if (prev[g]) begin
        checks++;
        gap[g] = 1;
        if (lenq[g].size() == 0) begin
          failures++;
          $display("FAIL txlen dut%0d unexpected frame got=%0d required=none",
                   g, run[g]);
        end else begin
          l = lenq[g].pop_front();
          if (run[g] != l) begin
            failures++;
            $display("FAIL txlen dut%0d got=%0d required=%0d", g, run[g], l);
          end
        end
      end else begin
        gap[g]++;
      end
    end
    prev[g] = txen[g];
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic mk_body(input int n, input int mul, input int add);
    body.delete();
    for (int i = 0; i < n; i++) body.push_back(8'((i * mul + add) & 255));
  endtask

  task automatic push_pre(input int g);
    for (int i = 0; i < 7; i++) expq[g].push_back(8'h55);
    expq[g].push_back(8'hD5);
  endtask

  task automatic expect_frame(input int g, input int n);
    logic [31:0] c;
    int minl, maxl, m, len;
    bit o;
    minl = (g == 0) ? 60 : 1;
    maxl = (g == 0) ? 1514 : 64;
    o = (n >= maxl);
    m = o ? maxl : n;
    c = 32'hFFFFFFFF;
    push_pre(g);
    for (int i = 0; i < m; i++) begin
      expq[g].push_back(body[i]);
      c = crc_upd(c, body[i]);
    end
    for (int i = m; i < minl; i++) begin
      expq[g].push_back(8'h00);
      c = crc_upd(c, 8'h00);
    end
    len = 8 + ((m < minl) ? minl : m) + 4;
    if (!o) c = ~c;
    for (int k = 0; k < 4; k++) expq[g].push_back(c[8*k +: 8]);
    lenq[g].push_back(len);
    fexp[g]++;
  endtask

  task automatic send(input int g, input int n);
    int t;
    sv[g] = 1'b1;
    sd[g] = (n > 0) ? body[0] : 8'h00;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ack[g] && t < 400);
    chk("ack_wait", 32'(ack[g]), 32'd1);
    for (int i = 0; i < n; i++) begin
      sd[g] = body[i];
      @(negedge clk);
    end
    sv[g] = 1'b0;
    sd[g] = 8'h00;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int g);
    int t;
    t = 0;
    while ((expq[g].size() != 0 || lenq[g].size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 32'(t < 3000), 32'd1);
    repeat (16) @(negedge clk);
  endtask

  int a0, h0, o0;

  initial begin
    areset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      sv[g] = 1'b0; sd[g] = 8'h00; fexp[g] = 0;
      ack_n[g] = 0; ovs_n[g] = 0; hi_n[g] = 0;
      last_gap[g] = 0; gap[g] = 0; run[g] = 0; prev[g] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_txen", 32'(txen[g]), 32'd0);
      chk("rst_txd", 32'(txd[g]), 32'd0);
      chk("rst_ack", 32'(ack[g]), 32'd0);
      chk("rst_ovs", 32'(ovs[g]), 32'd0);
      chk("rst_fcnt", 32'(fcnt[g]), 32'd0);
    end
    areset = 1'b0;
    repeat (2) @(negedge clk);

    // ARP-sized body on defaults
    mk_body(42, 7, 3);
    body[0] = 8'hFF; body[12] = 8'h08; body[13] = 8'h06;
    expect_frame(0, 42);
    a0 = ack_n[0];
    send(0, 42);
    wait_idle(0);
    chk("arp_ack_once", 32'(ack_n[0] - a0), 32'd1);
    chk("arp_fcnt", 32'(fcnt[0]), 32'(fexp[0]));

    // back-to-back, S_VALID re-raised right after the body ends
    mk_body(42, 5, 11);
    expect_frame(0, 42);
    expect_frame(0, 42);
    send(0, 42);
    send(0, 42);
    wait_idle(0);
    chk("b2b_ifg_gap", 32'(last_gap[0]), 32'd12);
    chk("b2b_fcnt", 32'(fcnt[0]), 32'(fexp[0]));

    // zero-length body
    body.delete();
    expect_frame(0, 0);
    a0 = ack_n[0];
    send(0, 0);
    wait_idle(0);
    chk("zero_ack_once", 32'(ack_n[0] - a0), 32'd1);
    chk("zero_fcnt", 32'(fcnt[0]), 32'(fexp[0]));

    // oversize truncation on the small-MAX instance
    mk_body(100, 3, 1);
    expect_frame(1, 100);
    h0 = hi_n[1];
    o0 = ovs_n[1];
    send(1, 100);
    wait_idle(1);
    chk("ovs_tx_cycles", 32'(hi_n[1] - h0), 32'd76);
    chk("ovs_pulse_once", 32'(ovs_n[1] - o0), 32'd1);
    chk("ovs_fcnt", 32'(fcnt[1]), 32'(fexp[1]));

    // "123456789" with MIN_LEN=1: known CRC-32 check value
    mk_body(9, 1, 8'h31);
    push_pre(1);
    for (int i = 0; i < 9; i++) expq[1].push_back(body[i]);
    expq[1].push_back(8'h26);
    expq[1].push_back(8'h39);
    expq[1].push_back(8'hF4);
    expq[1].push_back(8'hCB);
    lenq[1].push_back(21);
    fexp[1]++;
    send(1, 9);
    wait_idle(1);
    chk("crc_check_fcnt", 32'(fcnt[1]), 32'(fexp[1]));

    // reset while body byte 20 is on the wire
    mk_body(42, 9, 2);
    expect_frame(0, 42);
    sv[0] = 1'b1;
    sd[0] = body[0];
    a0 = 0;
    do begin
      @(negedge clk);
      a0++;
    end while (!ack[0] && a0 < 400);
    for (int i = 0; i < 20; i++) begin
      sd[0] = body[i];
      @(negedge clk);
    end
    sd[0] = body[20];
    @(posedge clk);
    #2;
    chk("pre_rst_byte20", 32'(txd[0]), 32'(body[20]));
    areset = 1'b1;
    #1;
    chk("async_rst_txen", 32'(txen[0]), 32'd0);
    chk("async_rst_ack", 32'(ack[0]), 32'd0);
    chk("async_rst_fcnt", 32'(fcnt[0]), 32'd0);
    expq[0].delete();
    lenq[0].delete();
    fexp[0] = 0;
    sv[0] = 1'b0;
    sd[0] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);

    // clean frame after reset
    mk_body(42, 13, 5);
    expect_frame(0, 42);
    send(0, 42);
    wait_idle(0);
    chk("post_rst_fcnt", 32'(fcnt[0]), 32'(fexp[0]));
    chk("no_ovs_dflt", 32'(ovs_n[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
